// File: rtl/div_unit_pkg.sv
// +--------------------------------------------------------------------+
// | div_unit_pkg : shared CPU defines used by the multi-cycle divider  |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic RstEnable         = 1'b1;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  function automatic logic [RegBus-1:0] twos_neg(input logic [RegBus-1:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// +--------------------------------------------------------------------+
// | div_unit : 32-iteration restoring divider for MIPS DIV/DIVU         |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
`default_nettype none

module div_unit
  import div_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e r_state;
  div_state_e w_state_nxt;

  // r_work = {spare bit, partial remainder, dividend shifting out / quotient shifting in}
  logic [64:0]       r_work;
  logic [RegBus-1:0] r_divisor;
  logic [5:0]        r_cnt;
  logic              r_quot_neg;
  logic              r_rem_neg;

  logic              w_accept;
  logic [RegBus-1:0] w_op1_mag;
  logic [RegBus-1:0] w_op2_mag;
  logic [33:0]       w_shift;
  logic [33:0]       w_diff;
  logic              w_qbit;
  logic [32:0]       w_rem_nxt;
  logic [RegBus-1:0] w_quo_fix;
  logic [RegBus-1:0] w_rem_fix;

  assign w_accept  = (start_i == DivStart) && !annul_i;
  assign w_op1_mag = (signed_div_i && opdata1_i[31]) ? twos_neg(opdata1_i) : opdata1_i;
  assign w_op2_mag = (signed_div_i && opdata2_i[31]) ? twos_neg(opdata2_i) : opdata2_i;

  // The partial remainder stays below the divisor, so the shifted value is under
  // 2^33 and a 34-bit difference carries a reliable sign bit.
  assign w_shift   = {r_work[64:32], r_work[31]};
  assign w_diff    = w_shift - {2'b00, r_divisor};
  assign w_qbit    = ~w_diff[33];
  assign w_rem_nxt = w_qbit ? w_diff[32:0] : w_shift[32:0];

  assign w_quo_fix = r_quot_neg ? twos_neg(r_work[31:0])  : r_work[31:0];
  assign w_rem_fix = r_rem_neg  ? twos_neg(r_work[63:32]) : r_work[63:32];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= DivFree;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DivFree: begin
        if (w_accept) begin
          w_state_nxt = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
        end
      end
      DivByZero: w_state_nxt = DivEnd;
      DivOn: begin
        if (annul_i) begin
          w_state_nxt = DivFree;
        end else if (r_cnt == 6'd31) begin
          w_state_nxt = DivEnd;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          w_state_nxt = DivFree;
        end
      end
      default: w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_work     <= '0;
      r_divisor  <= ZeroWord;
      r_cnt      <= 6'd0;
      r_quot_neg <= 1'b0;
      r_rem_neg  <= 1'b0;
      ready_o    <= DivResultNotReady;
      result_o   <= '0;
    end else begin
      case (r_state)
        DivFree: begin
          if (w_accept) begin
            r_work     <= (opdata2_i == ZeroWord) ? 65'd0 : {33'd0, w_op1_mag};
            r_divisor  <= w_op2_mag;
            r_cnt      <= 6'd0;
            r_quot_neg <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_rem_neg  <= signed_div_i & opdata1_i[31];
          end
        end
        DivOn: begin
          if (!annul_i) begin
            r_work <= {w_rem_nxt, r_work[30:0], w_qbit};
            r_cnt  <= r_cnt + 6'd1;
          end
        end
        default: ;
      endcase

      // Sign correction is folded into the result register, so the result
      // only ever shows the corrected value while END holds.
      if (r_state == DivEnd && start_i == DivStart) begin
        ready_o  <= DivResultReady;
        result_o <= {w_rem_fix, w_quo_fix};
      end else begin
        ready_o  <= DivResultNotReady;
        result_o <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// +--------------------------------------------------------------------+
// | tb_div_unit : directed self-checking bench for div_unit             |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Start at edge N, scramble operands mid-flight, expect ready exactly at N+33,
  // hold one extra END cycle, then release start and expect outputs cleared.
  task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    step();
    opdata1_i = ~a;
    opdata2_i = b + 32'd5;
    repeat (32) step();
    check({tag, "_not_ready_n32"}, {63'd0, ready_o}, 64'd0);
    step();
    check({tag, "_ready_n33"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_result"}, result_o, exp);
    step();
    check({tag, "_result_held"}, result_o, exp);
    start_i = 1'b0;
    step();
    check({tag, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_result_clear"}, result_o, 64'd0);
  endtask

  initial begin
    logic saw_ready;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    step();
    step();
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    step();

    do_op("divu_7_2",    1'b0, 32'd7,        32'd2,        {32'h0000_0001, 32'h0000_0003});
    do_op("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,       {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("div_7_m2",    1'b1, 32'd7,        32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
    do_op("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    do_op("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,       {32'h0000_0000, 32'hFFFF_FFFF});
    do_op("divu_big",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000});

    // Divide by zero: ready at N+2, stays while start holds, immune to annul.
    signed_div_i = 1'b1;
    opdata1_i    = 32'h1234_5678;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    step();
    step();
    check("byzero_not_ready_n1", {63'd0, ready_o}, 64'd0);
    step();
    check("byzero_ready_n2", {63'd0, ready_o}, 64'd1);
    check("byzero_result", result_o, 64'd0);
    annul_i   = 1'b1;
    opdata2_i = 32'd3;
    step();
    annul_i = 1'b0;
    step();
    check("byzero_ready_hold", {63'd0, ready_o}, 64'd1);
    start_i = 1'b0;
    step();
    check("byzero_ready_drop", {63'd0, ready_o}, 64'd0);

    // annul in FREE blocks the start; latency of the later op proves it.
    start_i   = 1'b1;
    annul_i   = 1'b1;
    opdata1_i = 32'd1;
    opdata2_i = 32'd1;
    repeat (3) step();
    annul_i = 1'b0;
    do_op("divu_1000_3", 1'b0, 32'd1000, 32'd3, {32'h0000_0001, 32'h0000_014D});

    // annul at iteration 10 kills the operation.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    step();
    repeat (10) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    annul_i   = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      step();
      if (ready_o) saw_ready = 1'b1;
    end
    check("annul_no_ready", {63'd0, saw_ready}, 64'd0);
    do_op("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});

    // Reset at iteration 20 with start held across it.
    opdata1_i = 32'd7;
    opdata2_i = 32'd2;
    start_i   = 1'b1;
    step();
    repeat (20) step();
    rst = 1'b1;
    step();
    check("midrst_ready", {63'd0, ready_o}, 64'd0);
    check("midrst_result", result_o, 64'd0);
    rst = 1'b0;
    do_op("post_rst_7_2", 1'b0, 32'd7, 32'd2, {32'h0000_0001, 32'h0000_0003});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the MIPS DIV/DIVU instructions. The execute stage is the initiator: it raises a start request with both operands and a signed flag, then stalls the pipeline until the divider reports a result. The divider returns a 64-bit {remainder, quotient} word, which the execute stage drives onto its HI/LO write port: HI = remainder, LO = quotient. Completion takes 32 iterations of restoring division, one quotient bit per cycle.

## Interface
Parameters: none; widths come from the shared CPU defines package (RegBus 32, DoubleRegBus 64).
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request level, held by EX until it has consumed the result
- annul_i  in  1  cancel in-flight division (pipeline flush / exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result valid

## Operation
- States: FREE, BYZERO, ON, END. Internal: 65-bit work register {partial remainder, dividend/quotient}, 6-bit iteration counter, latched sign flags.
- FREE: when start_i=1 and annul_i=0:
  - If opdata2_i=0, go to BYZERO.
  - Otherwise go to ON. Latch the operands; for signed division replace negative operands with their two's complement. Latch quot_neg = op1[31]^op2[31] and rem_neg = op1[31] (signed only). Counter = 0.
- BYZERO: next cycle go to END with result 0.
- ON, per cycle: trial = partial_rem[31:0]<<1 | next dividend bit, minus divisor.
  - trial non-negative: keep it and shift in quotient bit 1.
  - otherwise: shift in 0.
  - Counter increments. After the 32nd step, go to END.
  - Correction on entering END: negate the quotient if quot_neg; negate the remainder if rem_neg.
- ON with annul_i=1: go to FREE immediately; no result is produced.
- END: ready_o=1; result_o holds the value. When start_i falls to 0, go to FREE; ready_o goes to 0 and result_o to 0.
- Arithmetic: all magnitudes are unsigned 32-bit. Signed -2^31 / -1 wraps to quotient 0x80000000, remainder 0, with no trap. Remainder sign always follows the dividend.
- annul_i in FREE, BYZERO or END: no effect beyond blocking a new start in FREE.

## Timing
- Reset value of every output and register is 0; state is FREE.
- Reset mid-operation: state goes to FREE and outputs to 0 on the next edge; the operation is lost.
- Non-zero divisor: start seen in FREE at edge N; ON during N+1..N+32; ready_o=1 and result valid from edge N+33.
- Zero divisor: ready_o=1 from edge N+2.
- ready_o and result_o are registered, with no combinational path from the inputs.
- ready_o stays high for as long as start_i stays high in END.
- start_i deasserted in END at edge M: ready_o=0 at M+1, and a new start is accepted at M+1.
- Back-to-back operation needs at least one start_i=0 cycle between requests.
- Operand changes while in ON/END are ignored because the operands are latched.

## Structure
- Shared defines package holds:
  - state encodings DivFree/DivByZero/DivOn/DivEnd
  - DivResultReady/NotReady and DivStart/Stop
  - ZeroWord and DoubleRegBus
  - RstEnable
- Single module with no sub-module; the one-step subtractor is inline combinational logic.

## Test plan
- DIVU 7/2: result_o = {0x00000001, 0x00000003}; ready_o rises exactly 33 cycles after start.
- DIV -7/2 (0xFFFFFFF9 / 2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; DIVU 0xFFFFFFFF/1: quotient 0xFFFFFFFF, remainder 0.
- Divide by zero (any dividend): ready_o at cycle +2, result 0.
- annul_i pulsed at iteration 10: ready_o never asserts, state returns to FREE; a following DIVU 100/7 gives {2, 14}.
- rst at iteration 20: all outputs 0 next cycle; start held across the reset restarts cleanly and ready_o comes 33 cycles after reset release.
